// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Ops and FSM states are plain localparams so older modules can use the same constants.
package muldiv_pkg;

  localparam int DEF_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CALC  = 2'd1;
  localparam logic [1:0] FIXUP = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide datapath: shift-add multiply or restoring divide.
// For multiply, acc is {partial product, remaining multiplier}; for divide it is {remainder, dividend/quotient}.
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2*WIDTH-1:0] acc,
  input  logic [WIDTH-1:0]   operand,
  input  logic               is_div,
  output logic [2*WIDTH-1:0] acc_next,
  output logic               q_bit
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] diff;

  // The remainder after a successful subtract is always below the divisor, so WIDTH bits suffice for diff.
  always_comb begin
    sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : {(WIDTH+1){1'b0}});
    trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    diff     = trial[WIDTH-1:0] - operand;
    q_bit    = 1'b0;
    acc_next = {sum, acc[WIDTH-1:1]};
    if (is_div) begin
      q_bit    = (trial >= {1'b0, operand});
      acc_next = {(q_bit ? diff : trial[WIDTH-1:0]), acc[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer with HI/LO registers and MTHI/MTLO writes.
// Fixed 34-cycle latency: 32 CALC iterations, one FIXUP for signs, one DONE pulse.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [1:0]         op_q;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] step_acc;
  logic               step_q;
  logic [WIDTH-1:0]   operand_q;
  logic [WIDTH-1:0]   rs_orig;
  logic               sign_a;
  logic               sign_b;
  logic               dbz;

  logic               op_signed;
  logic               op_div;
  logic               cur_div;
  logic [WIDTH-1:0]   rs_abs;
  logic [WIDTH-1:0]   rt_abs;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign op_signed = (op == OP_MULT) || (op == OP_DIV);
  assign op_div    = (op == OP_DIV)  || (op == OP_DIVU);
  assign cur_div   = !((op_q == OP_MULT) || (op_q == OP_MULTU));

  // Signed ops iterate on magnitudes; the sign bits are reapplied in FIXUP.
  assign rs_abs = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
  assign rt_abs = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

  assign prod_fix = (sign_a ^ sign_b) ? -acc : acc;
  assign quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign rem_fix  = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

  assign busy        = (state != IDLE);
  assign done        = (state == DONE);
  assign div_by_zero = (state == DONE) && dbz;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .acc      (acc),
    .operand  (operand_q),
    .is_div   (cur_div),
    .acc_next (step_acc),
    .q_bit    (step_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      op_q      <= '0;
      acc       <= '0;
      operand_q <= '0;
      rs_orig   <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      dbz       <= 1'b0;
      hi        <= '0;
      lo        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !flush) begin
            op_q      <= op;
            rs_orig   <= rs_val;
            sign_a    <= op_signed && rs_val[WIDTH-1];
            sign_b    <= op_signed && rt_val[WIDTH-1];
            dbz       <= op_div && (rt_val == '0);
            acc       <= op_div ? {{WIDTH{1'b0}}, rs_abs} : {{WIDTH{1'b0}}, rt_abs};
            operand_q <= op_div ? rt_abs : rs_abs;
            cnt       <= CNT_W'(WIDTH - 1);
            state     <= CALC;
          end else if (!start) begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            acc <= {step_acc[2*WIDTH-1:1], cur_div ? step_q : step_acc[0]};
            if (cnt == '0) state <= FIXUP;
            else           cnt   <= cnt - 1'b1;
          end
        end
        FIXUP: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            // A zero divisor reports all-ones quotient and the untouched dividend instead of the iterated result.
            if (dbz) begin
              lo <= '1;
              hi <= rs_orig;
            end else if (cur_div) begin
              lo <= quo_fix;
              hi <= rem_fix;
            end else begin
              hi <= prod_fix[2*WIDTH-1:WIDTH];
              lo <= prod_fix[WIDTH-1:0];
            end
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, hand-written corner sequences,
// and random operations compared against a plain-arithmetic reference model.
module tb_muldiv_sequencer;
  import muldiv_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        flush;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] sh_hi;
  logic [31:0] sh_lo;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] ehi;
    logic [31:0] elo;
    logic        edbz;
  } vec_t;

  vec_t vecs[$];

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .flush       (flush),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .wdata       (wdata),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference results straight from integer arithmetic, with the architected special cases.
  function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] h, output logic [31:0] l, output logic z);
    longint      p;
    logic [63:0] u;
    int          sa;
    int          sb;
    int          q;
    int          r;
    z = 1'b0;
    h = '0;
    l = '0;
    case (o)
      OP_MULT: begin
        p = longint'($signed(a)) * longint'($signed(b));
        h = p[63:32];
        l = p[31:0];
      end
      OP_MULTU: begin
        u = {32'b0, a} * {32'b0, b};
        h = u[63:32];
        l = u[31:0];
      end
      OP_DIV: begin
        if (b == 32'd0) begin
          z = 1'b1; l = 32'hFFFFFFFF; h = a;
        end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
          l = 32'h80000000; h = 32'd0;
        end else begin
          sa = a; sb = b;
          q = sa / sb; r = sa % sb;
          l = q; h = r;
        end
      end
      default: begin
        if (b == 32'd0) begin
          z = 1'b1; l = 32'hFFFFFFFF; h = a;
        end else begin
          l = a / b; h = a % b;
        end
      end
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Launches one op and watches 36 cycles after the start edge; optional flush, restart and
  // register-write events are injected at given cycle offsets (0 = none).
  task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                               input int flush_k, input int restart_k, input int wr_k, input bit lowe0,
                               output int done_k, output int done_cnt, output int busy_bad,
                               output bit dbz_seen, output int dbz_stray);
    bit exp_busy;
    @(negedge clk);
    start = 1'b1; op = o; rs_val = a; rt_val = b;
    lo_we = lowe0; wdata = 32'hDEADBEEF;
    done_k = 0; done_cnt = 0; busy_bad = 0; dbz_seen = 1'b0; dbz_stray = 0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (done) begin
        done_cnt++;
        if (done_k == 0) done_k = k;
        if (div_by_zero) dbz_seen = 1'b1;
      end else if (div_by_zero) begin
        dbz_stray++;
      end
      exp_busy = (flush_k > 0) ? (k <= flush_k) : (k <= 34);
      if (busy !== exp_busy) busy_bad++;
      start = (k == restart_k);
      if (k == restart_k) begin
        op = OP_DIVU; rs_val = 32'd9; rt_val = 32'd0;
      end
      flush = (k == flush_k);
      hi_we = (k == wr_k);
      lo_we = (k == wr_k);
      wdata = 32'h55555555;
    end
    start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
  endtask

  task automatic runCase(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input int flush_k, input int restart_k, input int wr_k, input bit lowe0,
                         input logic [31:0] ehi, input logic [31:0] elo, input logic edbz);
    int done_k;
    int done_cnt;
    int busy_bad;
    bit dbz_seen;
    int dbz_stray;
    bit flushed;
    applyStimulus(o, a, b, flush_k, restart_k, wr_k, lowe0, done_k, done_cnt, busy_bad, dbz_seen, dbz_stray);
    flushed = (flush_k > 0);
    checkOutput($sformatf("%s done_cycle", name), 64'(done_k), flushed ? 64'd0 : 64'd34);
    checkOutput($sformatf("%s done_pulses", name), 64'(done_cnt), flushed ? 64'd0 : 64'd1);
    checkOutput($sformatf("%s busy_errs", name), 64'(busy_bad), 64'd0);
    checkOutput($sformatf("%s dbz", name), 64'(dbz_seen), 64'(edbz));
    checkOutput($sformatf("%s dbz_stray", name), 64'(dbz_stray), 64'd0);
    checkOutput($sformatf("%s hi", name), 64'(hi), 64'(ehi));
    checkOutput($sformatf("%s lo", name), 64'(lo), 64'(elo));
    sh_hi = ehi;
    sh_lo = elo;
  endtask

  initial begin
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] eh;
    logic [31:0] el;
    logic        ez;
    int          cnt_busy;
    int          cnt_done;

    rst_n = 1'b0; start = 1'b0; op = '0; rs_val = '0; rt_val = '0;
    flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    sh_hi = '0; sh_lo = '0;

    vecs.push_back('{OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0});
    vecs.push_back('{OP_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0});
    vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{OP_DIVU,  32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1});
    vecs.push_back('{OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0});
    vecs.push_back('{OP_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0});
    vecs.push_back('{OP_DIV,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1});
    vecs.push_back('{OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0});
    vecs.push_back('{OP_MULT,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0});
    vecs.push_back('{OP_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0});
    vecs.push_back('{OP_MULTU, 32'h00000006, 32'h00000007, 32'h00000000, 32'h0000002A, 1'b0});

    repeat (2) @(negedge clk);
    checkOutput("reset hi", 64'(hi), 64'd0);
    checkOutput("reset lo", 64'(lo), 64'd0);
    checkOutput("reset busy", 64'(busy), 64'd0);
    checkOutput("reset done", 64'(done), 64'd0);
    checkOutput("reset dbz", 64'(div_by_zero), 64'd0);
    rst_n = 1'b1;

    foreach (vecs[i])
      runCase($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0, 0, 0, 1'b0,
              vecs[i].ehi, vecs[i].elo, vecs[i].edbz);

    // MTHI in IDLE, then a DIV squashed by flush part way through.
    @(negedge clk);
    hi_we = 1'b1; wdata = 32'hAAAA0000;
    @(negedge clk);
    hi_we = 1'b0;
    checkOutput("mthi hi", 64'(hi), 64'hAAAA0000);
    sh_hi = 32'hAAAA0000;
    runCase("div_flush", OP_DIV, 32'd100, 32'd7, 10, 0, 0, 1'b0, sh_hi, sh_lo, 1'b0);
    runCase("div_restart", OP_DIV, 32'd100, 32'd7, 0, 0, 0, 1'b0, 32'd2, 32'd14, 1'b0);

    // start with lo_we in the same cycle, a second start while busy, and writes while busy.
    runCase("start_lowe", OP_MULTU, 32'd3, 32'd4, 0, 5, 8, 1'b1, 32'd0, 32'd12, 1'b0);

    // flush together with start in IDLE must not launch anything.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = OP_DIVU; rs_val = 32'd50; rt_val = 32'd5;
    cnt_busy = 0; cnt_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      if (busy) cnt_busy++;
      if (done) cnt_done++;
    end
    checkOutput("flush_start busy", 64'(cnt_busy), 64'd0);
    checkOutput("flush_start done", 64'(cnt_done), 64'd0);
    checkOutput("flush_start hi", 64'(hi), 64'(sh_hi));
    checkOutput("flush_start lo", 64'(lo), 64'(sh_lo));

    // Reset in the middle of a MULT clears everything at once.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; rs_val = 32'h00001234; rt_val = 32'hFFFF0001;
    @(negedge clk);
    start = 1'b0;
    repeat (19) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst hi", 64'(hi), 64'd0);
    checkOutput("midrst lo", 64'(lo), 64'd0);
    checkOutput("midrst busy", 64'(busy), 64'd0);
    checkOutput("midrst done", 64'(done), 64'd0);
    checkOutput("midrst dbz", 64'(div_by_zero), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sh_hi = '0; sh_lo = '0;
    runCase("post_rst", OP_MULTU, 32'd6, 32'd7, 0, 0, 0, 1'b0, 32'd0, 32'd42, 1'b0);

    for (int n = 0; n < 30; n++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h80000000;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(8, 28);
      model(ro, ra, rb, eh, el, ez);
      runCase($sformatf("rand%0d op%0d %h %h", n, ro, ra, rb), ro, ra, rb, 0, 0, 0, 1'b0, eh, el, ez);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
